// File: rtl/ram_pkg.sv
// Shared definitions for the wait-state data memory: access size codes,
// controller state encoding and the wait counter width.
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_byte_array.sv
// DEPTH x 8 storage presenting four consecutive bytes from a base offset;
// lane 3 is the byte at base (big-endian), offsets wrap modulo DEPTH.
module ram_byte_array #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic [3:0]    we,
  input  logic [AW-1:0] base,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;

  assign a1 = base + AW'(1);
  assign a2 = base + AW'(2);
  assign a3 = base + AW'(3);

  always_ff @(posedge CLK) begin
    if (we[3]) mem[base] <= wdata[31:24];
    if (we[2]) mem[a1]   <= wdata[23:16];
    if (we[1]) mem[a2]   <= wdata[15:8];
    if (we[0]) mem[a3]   <= wdata[7:0];
  end

  assign rdata = {mem[base], mem[a1], mem[a2], mem[a3]};

endmodule

// File: rtl/ram_ws_param.sv
// Byte-addressable data memory with MOV/MOC handshake, configurable wait
// states, big-endian lane steering, alignment faults and BUSY status.
module ram_ws_param
  import ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              MOV,
  input  logic              ReadWrite,
  input  logic [2:0]        MS_2_0,
  input  logic [31:0]       DataIn,
  input  logic [ADDR_W-1:0] Address,
  output logic              MOC,
  output logic [31:0]       DataOut,
  output logic              FAULT,
  output logic              BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;

  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic [2:0]    ms_q;
  logic          rw_q;

  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        fault;
  logic        addr_unused;

  // Only the low AW address bits decode; the rest wrap away.
  assign addr_unused = ^Address[ADDR_W-1:AW];

  function automatic logic is_fault(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: is_fault = lo[0];
      SZ_WORD: is_fault = (lo != 2'b00);
      SZ_RSVD: is_fault = 1'b1;
      default: is_fault = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] raw);
    case (sz)
      SZ_BYTE: extend = {{24{sgn & raw[31]}}, raw[31:24]};
      SZ_HALF: extend = {{16{sgn & raw[31]}}, raw[31:16]};
      default: extend = raw;
    endcase
  endfunction

  assign fault = is_fault(ms_q[1:0], addr_q[1:0]);

  ram_byte_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .we    (we),
    .base  (addr_q),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Request capture: data only, no reset needed
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && MOV) begin
      addr_q <= Address[AW-1:0];
      din_q  <= DataIn;
      ms_q   <= MS_2_0;
      rw_q   <= ReadWrite;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (MOV) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cnt == WAIT_LAST) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   if (!MOV) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Write commits on the ACCESS edge; narrow data goes to the top lanes.
  always_comb begin
    we    = 4'b0000;
    wdata = 32'h0;
    if (state == ST_ACCESS && !rw_q && !fault) begin
      case (ms_q[1:0])
        SZ_BYTE: begin we = 4'b1000; wdata = {din_q[7:0], 24'h0};  end
        SZ_HALF: begin we = 4'b1100; wdata = {din_q[15:0], 16'h0}; end
        SZ_WORD: begin we = 4'b1111; wdata = din_q;                end
        default: begin we = 4'b0000; wdata = 32'h0;                end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt     <= '0;
      MOC     <= 1'b0;
      FAULT   <= 1'b0;
      BUSY    <= 1'b0;
      DataOut <= 32'h0;
    end else begin
      if (state == ST_WAIT && cnt != WAIT_LAST) cnt <= cnt + WAIT_CNT_W'(1);
      else                                       cnt <= '0;
      case (state)
        ST_IDLE: if (MOV) BUSY <= 1'b1;
        ST_ACCESS: begin
          MOC   <= 1'b1;
          FAULT <= fault;
          if (fault)     DataOut <= 32'h0;
          else if (rw_q) DataOut <= extend(ms_q[1:0], ms_q[2], rdata);
        end
        ST_DONE: begin
          if (!MOV) begin
            MOC   <= 1'b0;
            FAULT <= 1'b0;
            BUSY  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
